// File: rtl/mips_cpu_multiplier.sv
// Sequential shift-add multiplier for MIPS32 MULT/MULTU.
// Produces a 64-bit product as Hi:Lo using a 32-iteration shift-add loop.
// Signed operands are reduced to magnitudes, and the sign is re-applied at the end.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no result produced since reset
// S_RUN  | iterating (or finishing the zero-operand shortcut)
// S_DONE | Hi/Lo hold a valid result; ready for the next start
module mips_cpu_multiplier (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] Multiplicand,
    input  logic [31:0] Multiplier,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [32:0] acc_q, acc_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplr_q, mplr_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;
    logic        zero_q, zero_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [31:0] mag_a, mag_b;
    logic [32:0] sum;
    logic [64:0] shifted;
    logic [63:0] prod;

    // Next-state logic: accept a start, run one shift-add step per cycle, commit result.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        zero_d  = zero_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        sum     = 33'd0;
        shifted = 65'd0;
        prod    = 64'd0;
        // 0x80000000 negates to itself, which is the correct unsigned magnitude.
        mag_a   = Multiplicand[31] ? (~Multiplicand + 32'd1) : Multiplicand;
        mag_b   = Multiplier[31]   ? (~Multiplier + 32'd1)   : Multiplier;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    neg_d   = is_signed & (Multiplicand[31] ^ Multiplier[31]);
                    mcand_d = is_signed ? mag_a : Multiplicand;
                    mplr_d  = is_signed ? mag_b : Multiplier;
                    acc_d   = 33'd0;
                    cnt_d   = 5'd0;
                    zero_d  = (Multiplicand == 32'd0) || (Multiplier == 32'd0);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (zero_q) begin
                    // Either operand was zero: result is +0 regardless of sign.
                    hi_d    = 32'd0;
                    lo_d    = 32'd0;
                    state_d = S_DONE;
                end else begin
                    sum     = acc_q + (mplr_q[0] ? {1'b0, mcand_q} : 33'd0);
                    shifted = {sum, mplr_q} >> 1;
                    acc_d   = shifted[64:32];
                    mplr_d  = shifted[31:0];
                    cnt_d   = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        prod    = neg_q ? (~shifted[63:0] + 64'd1) : shifted[63:0];
                        hi_d    = prod[63:32];
                        lo_d    = prod[31:0];
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; synchronous reset aborts any operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= 33'd0;
            mcand_q <= 32'd0;
            mplr_q  <= 32'd0;
            cnt_q   <= 5'd0;
            neg_q   <= 1'b0;
            zero_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            zero_q  <= zero_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign Hi   = hi_q;
    assign Lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_multiplier.sv
// Self-checking bench for mips_cpu_multiplier: a behavioural model tracks
// busy/done/Hi/Lo, and the outputs are compared against it every cycle.
module tb_mips_cpu_multiplier;

    logic        clk;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int n_pass;
    int n_total;
    bit check_en;
    bit noise_en;

    // Behavioural model state
    bit          m_busy;
    bit          m_done;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [63:0] m_pend;
    int          m_rem;

    mips_cpu_multiplier dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .is_signed    (is_signed),
        .Multiplicand (a_in),
        .Multiplier   (b_in),
        .Hi           (hi),
        .Lo           (lo),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic s);
        longint          sa, sb;
        longint unsigned ua, ub;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
    endtask

    // Model: a start outside an operation schedules the product 32 edges later
    // (1 edge when an operand is zero); reset clears everything.
    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
            m_rem  <= 0;
        end else if (start && !m_busy) begin
            m_busy <= 1'b1;
            m_done <= 1'b0;
            m_pend <= ref_prod(a_in, b_in, is_signed);
            m_rem  <= (a_in == 32'd0 || b_in == 32'd0) ? 1 : 32;
        end else if (m_busy) begin
            if (m_rem == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_hi   <= m_pend[63:32];
                m_lo   <= m_pend[31:0];
            end
            m_rem <= m_rem - 1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            check("busy", 64'(busy), 64'(m_busy));
            check("done", 64'(done), 64'(m_done));
            check("hi", 64'(hi), 64'(m_hi));
            check("lo", 64'(lo), 64'(m_lo));
        end
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        a_in      = a;
        b_in      = b;
        is_signed = s;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a_in  = $urandom;
        b_in  = $urandom;
    endtask

    // lat counts edges after the accepting edge at the point done is observed.
    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        while (!done && lat < 40) begin
            if (noise_en && $urandom_range(0, 5) == 0) begin
                start     = 1'b1;
                a_in      = $urandom;
                b_in      = $urandom;
                is_signed = 1'($urandom);
            end
            @(negedge clk);
            start = 1'b0;
            lat++;
        end
        if (!done) $display("FAIL timeout waiting for done t=%0t", $time);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input bit pin, input logic [31:0] eh, input logic [31:0] el);
        int lat;
        issue(a, b, s);
        wait_done(0, lat);
        check("latency", 64'(lat), (a == 32'd0 || b == 32'd0) ? 64'd1 : 64'd32);
        if (pin) begin
            check("pin_model", ref_prod(a, b, s), {eh, el});
            check("pin_hi", 64'(hi), 64'(eh));
            check("pin_lo", 64'(lo), 64'(el));
        end
    endtask

    initial begin
        int lat;
        n_pass    = 0;
        n_total   = 0;
        check_en  = 1'b0;
        noise_en  = 1'b0;
        reset     = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        a_in      = 32'd0;
        b_in      = 32'd0;
        repeat (2) @(negedge clk);
        check_en = 1'b1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op(32'hFFFF_FFFD, 32'd7,         1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op(32'h8000_0000, 32'd1,         1'b1, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 32'h4000_0000, 32'h0000_0000);
        run_op(32'h8000_0000, 32'd2,         1'b0, 1'b1, 32'h0000_0001, 32'h0000_0000);
        run_op(32'd0,         32'h1234_5678, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000);
        run_op(32'd5,         32'd9,         1'b0, 1'b1, 32'h0000_0000, 32'd45);

        // Start while busy is ignored.
        issue(32'd6, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        a_in  = 32'd100;
        b_in  = 32'd100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(10, lat);
        check("busy_start_lat", 64'(lat), 64'd32);
        check("busy_start_hi", 64'(hi), 64'd0);
        check("busy_start_lo", 64'(lo), 64'd42);

        // Reset mid-operation aborts without writing a result.
        issue(32'h0001_0000, 32'h0001_0000, 1'b0);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        run_op(32'h0001_0000, 32'h0001_0000, 1'b0, 1'b1, 32'h0000_0001, 32'h0000_0000);

        // Randomized operations, back-to-back or with short gaps, with stray starts.
        noise_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            run_op(pick(), pick(), 1'($urandom), 1'b0, 32'd0, 32'd0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        noise_en = 1'b0;
        @(negedge clk);

        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
